// File: rtl/note_scheduler.sv
// -----------------------------------------------------------------------------
// note_scheduler
//   Decodes PS/2 scan-code bytes into piano key presses and releases. It keeps
//   a last-pressed-priority stack of the keys that are held, and plays the top
//   key as a square wave.
//
// Ports
//   CLK          in   system clock, all state changes on the rising edge
//   RST_N        in   asynchronous active-low reset
//   rx_byte      in   [7:0] scan-code byte from the keyboard receiver
//   rx_valid     in   one-cycle strobe qualifying rx_byte
//   note_period  out  [19:0] half-period of the sounding note in CLK cycles, 0 when silent
//   note_active  out  high while any mapped key is held
//   tone_out     out  registered square wave that toggles every note_period cycles
//   held_count   out  [2:0] number of valid stack entries
//   dbg_state_o  out  [1:0] prefix FSM state (0 IDLE, 1 BRK, 2 EXT, 3 EXT_BRK)
//
// Handshake: there is no back-pressure. A byte is consumed on every rising
// edge where rx_valid=1, and rx_byte is ignored in all other cycles.
// -----------------------------------------------------------------------------
module note_scheduler #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [19:0] note_period,
    output logic        note_active,
    output logic        tone_out,
    output logic [2:0]  held_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [2:0] DEPTH_C = 3'(STACK_DEPTH);

    // Scan code to half-period table. A result of 0 means the code is not a piano key.
    function automatic logic [19:0] key_period(input logic [7:0] code);
        logic [19:0] p;
        case (code)
            8'h1A: p = 20'd95555;   8'h22: p = 20'd85132;   8'h21: p = 20'd75843;
            8'h2A: p = 20'd71586;   8'h32: p = 20'd63776;   8'h31: p = 20'd56818;
            8'h3A: p = 20'd50620;
            8'h1C: p = 20'd190840;  8'h1B: p = 20'd173611;  8'h23: p = 20'd151515;
            8'h2B: p = 20'd142857;  8'h34: p = 20'd127551;  8'h33: p = 20'd113636;
            8'h3B: p = 20'd101239;
            8'h15: p = 20'd382205;  8'h1D: p = 20'd340507;  8'h24: p = 20'd303361;
            8'h2D: p = 20'd286336;  8'h2C: p = 20'd255102;  8'h35: p = 20'd227273;
            8'h3C: p = 20'd202478;
            8'h16: p = 20'd764526;  8'h1E: p = 20'd681013;  8'h26: p = 20'd606796;
            8'h25: p = 20'd572737;  8'h2E: p = 20'd510204;  8'h36: p = 20'd454545;
            8'h3D: p = 20'd404924;
            default: p = 20'd0;
        endcase
        return p;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  stack_q [STACK_DEPTH];   // index 0 = oldest, held_q-1 = top
    logic [7:0]  stack_d [STACK_DEPTH];
    logic [2:0]  held_q, held_d;
    logic [19:0] period_q, period_d;
    logic        active_q, active_d;
    logic [19:0] cnt_q, cnt_d;
    logic        tone_q, tone_d;

    logic        do_press, do_release, mapped, hit;
    logic [2:0]  hit_idx;
    logic [7:0]  top_code;

    // ---------------- prefix FSM and key stack ----------------
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        stack_d    = stack_q;
        do_press   = 1'b0;
        do_release = 1'b0;
        hit        = 1'b0;
        hit_idx    = 3'd0;
        mapped     = (key_period(rx_byte) != 20'd0);

        // Lowest position holding this code. Presses never duplicate, so there is at most one.
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!hit && (i < int'(held_q)) && (stack_q[i] == rx_byte)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == 8'hF0)      state_d = BRK;
                    else if (rx_byte == 8'hE0) state_d = EXT;
                    else                       do_press = 1'b1;
                end
                BRK: begin
                    // A repeated prefix inside a break sequence is absorbed.
                    if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
                        do_release = 1'b1;
                        state_d    = IDLE;
                    end
                end
                EXT:     state_d = (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (do_press && mapped && !hit) begin
            if (held_q == DEPTH_C) begin
                // Full: evict the oldest entry and push on top.
                for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i + 1];
                stack_d[STACK_DEPTH - 1] = rx_byte;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (i == int'(held_q)) stack_d[i] = rx_byte;
                end
                held_d = held_q + 3'd1;
            end
        end

        if (do_release && mapped && hit) begin
            // Close the gap. The order of the remaining keys is kept.
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (i >= int'(hit_idx)) stack_d[i] = stack_q[i + 1];
            end
            stack_d[STACK_DEPTH - 1] = 8'h00;
            held_d = held_q - 3'd1;
        end
    end

    // ---------------- note selection (one edge behind the stack) ----------------
    always_comb begin
        top_code = 8'h00;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (i + 1 == int'(held_q)) top_code = stack_q[i];
        end
        active_d = (held_q != 3'd0);
        period_d = active_d ? key_period(top_code) : 20'd0;
    end

    // ---------------- tone generator ----------------
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!active_d) begin
            cnt_d  = 20'd0;
            tone_d = 1'b0;
        end else if (period_d != period_q) begin
            // A new pitch restarts the count. The output level is kept so there is no glitch.
            cnt_d = 20'd0;
        end else if (cnt_q == period_q - 20'd1) begin
            cnt_d  = 20'd0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            held_q   <= 3'd0;
            period_q <= 20'd0;
            active_q <= 1'b0;
            cnt_q    <= 20'd0;
            tone_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            period_q <= period_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign note_period = period_q;
    assign note_active = active_q;
    assign tone_out    = tone_q;
    assign held_count  = held_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [19:0] note_period;
  logic        note_active;
  logic        tone_out;
  logic [2:0]  held_count;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  note_scheduler #(.STACK_DEPTH(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .note_period(note_period),
    .note_active(note_active),
    .tone_out(tone_out),
    .held_count(held_count),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  code;
    logic [2:0]  held;
    logic [19:0] period;
    logic        active;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] code, input logic [2:0] held,
                     input logic [19:0] period, input logic active);
    vec_t v;
    v.code = code; v.held = held; v.period = period; v.active = active;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge, so the next rising edge samples them cleanly.
  task automatic strobe(input logic [7:0] b);
    @(negedge CLK);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    bit toggled;

    // ---- rows: code, held after stack edge, period/active one edge later ----
    add(8'h1A, 3'd1, 20'd95555,  1'b1);
    add(8'h1C, 3'd2, 20'd190840, 1'b1);
    add(8'hF0, 3'd2, 20'd190840, 1'b1);
    add(8'h1C, 3'd1, 20'd95555,  1'b1);
    add(8'hF0, 3'd1, 20'd95555,  1'b1);
    add(8'h1A, 3'd0, 20'd0,      1'b0);
    add(8'h16, 3'd1, 20'd764526, 1'b1);
    add(8'h1E, 3'd2, 20'd681013, 1'b1);
    add(8'h26, 3'd3, 20'd606796, 1'b1);
    add(8'h25, 3'd4, 20'd572737, 1'b1);
    add(8'h2E, 3'd4, 20'd510204, 1'b1);   // 16 is evicted
    add(8'hF0, 3'd4, 20'd510204, 1'b1);
    add(8'h16, 3'd4, 20'd510204, 1'b1);   // release of an evicted key: no change
    add(8'hF0, 3'd4, 20'd510204, 1'b1);
    add(8'h2E, 3'd3, 20'd572737, 1'b1);   // top released -> previous key sounds
    add(8'hF0, 3'd3, 20'd572737, 1'b1);
    add(8'h1E, 3'd2, 20'd572737, 1'b1);   // bottom released -> pitch unchanged
    add(8'hF0, 3'd2, 20'd572737, 1'b1);
    add(8'h25, 3'd1, 20'd606796, 1'b1);
    add(8'hF0, 3'd1, 20'd606796, 1'b1);
    add(8'h26, 3'd0, 20'd0,      1'b0);
    add(8'h1A, 3'd1, 20'd95555,  1'b1);
    add(8'h1A, 3'd1, 20'd95555,  1'b1);   // typematic repeat
    add(8'h1A, 3'd1, 20'd95555,  1'b1);
    add(8'hF0, 3'd1, 20'd95555,  1'b1);
    add(8'h1A, 3'd0, 20'd0,      1'b0);
    add(8'hE0, 3'd0, 20'd0,      1'b0);
    add(8'h1A, 3'd0, 20'd0,      1'b0);   // extended make is discarded
    add(8'hE0, 3'd0, 20'd0,      1'b0);
    add(8'hF0, 3'd0, 20'd0,      1'b0);
    add(8'h1A, 3'd0, 20'd0,      1'b0);   // extended break is discarded
    add(8'h5A, 3'd0, 20'd0,      1'b0);   // unmapped make
    add(8'hF0, 3'd0, 20'd0,      1'b0);
    add(8'h5A, 3'd0, 20'd0,      1'b0);   // unmapped break

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    check("rst_period", 32'(note_period), 32'd0);
    check("rst_active", 32'(note_active), 32'd0);
    check("rst_tone",   32'(tone_out),    32'd0);
    check("rst_held",   32'(held_count),  32'd0);
    check("rst_state",  32'(dbg_state_o), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // ---- table-driven sequence ----
    foreach (vecs[k]) begin
      strobe(vecs[k].code);
      check($sformatf("v%0d_held", k), 32'(held_count), 32'(vecs[k].held));
      @(negedge CLK);
      check($sformatf("v%0d_period", k), 32'(note_period), 32'(vecs[k].period));
      check($sformatf("v%0d_active", k), 32'(note_active), 32'(vecs[k].active));
      if (!vecs[k].active) check($sformatf("v%0d_tone", k), 32'(tone_out), 32'd0);
    end

    // ---- reset during a pending break prefix ----
    strobe(8'h1A);
    strobe(8'hF0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("mid_rst_period", 32'(note_period), 32'd0);
    check("mid_rst_active", 32'(note_active), 32'd0);
    check("mid_rst_held",   32'(held_count),  32'd0);
    check("mid_rst_tone",   32'(tone_out),    32'd0);
    check("mid_rst_state",  32'(dbg_state_o), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    strobe(8'h1A);
    check("post_rst_held", 32'(held_count), 32'd1);
    @(negedge CLK);
    check("post_rst_period", 32'(note_period), 32'd95555);
    check("post_rst_active", 32'(note_active), 32'd1);
    strobe(8'hF0);
    strobe(8'h1A);
    @(negedge CLK);
    check("post_rst_off", 32'(note_active), 32'd0);

    // ---- tone period: first toggle lands 50620 edges after the pitch loads ----
    strobe(8'h3A);
    @(negedge CLK);                      // the edge that loads note_period has now occurred
    check("tone_start", 32'(tone_out), 32'd0);
    n = 0;
    toggled = 1'b0;
    while (!toggled && n < 60000) begin
      @(negedge CLK);
      n++;
      if (tone_out) toggled = 1'b1;
    end
    check("tone_toggle_seen", 32'(toggled), 32'd1);
    check("tone_half_period", 32'(n), 32'd50620);

    // ---- pitch change keeps the level, and silence forces the output low ----
    strobe(8'h3B);
    @(negedge CLK);
    check("chg_period", 32'(note_period), 32'd101239);
    check("chg_tone_hold", 32'(tone_out), 32'd1);
    repeat (10) @(negedge CLK);
    check("chg_tone_stable", 32'(tone_out), 32'd1);
    strobe(8'hF0);
    strobe(8'h3B);
    @(negedge CLK);
    check("back_period", 32'(note_period), 32'd50620);
    check("back_tone_hold", 32'(tone_out), 32'd1);
    strobe(8'hF0);
    strobe(8'h3A);
    @(negedge CLK);
    check("silent_period", 32'(note_period), 32'd0);
    check("silent_tone", 32'(tone_out), 32'd0);
    check("silent_held", 32'(held_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
